// File: rtl/pcsrc_ctrl_if.sv
// Bundle of request and PC-update control signals between the instruction
// sequencer (master) and the next-PC controller (slave).
interface pcsrc_ctrl_if;
    logic       req_valid;
    logic [2:0] req_kind;
    logic       zero;
    logic       exc_opcode;
    logic       exc_overflow;
    logic       exc_div0;
    logic [2:0] pcsrc_selector;
    logic       pc_write;
    logic       epc_write;
    logic       alu_pc_minus4;
    logic       mem_read;
    logic [7:0] vec_addr;
    logic       busy;
    logic       done;

    modport master (
        output req_valid, req_kind, zero, exc_opcode, exc_overflow, exc_div0,
        input  pcsrc_selector, pc_write, epc_write, alu_pc_minus4, mem_read,
               vec_addr, busy, done
    );

    modport slave (
        input  req_valid, req_kind, zero, exc_opcode, exc_overflow, exc_div0,
        output pcsrc_selector, pc_write, epc_write, alu_pc_minus4, mem_read,
               vec_addr, busy, done
    );
endinterface

// File: rtl/pcsrc_ctrl.sv
// Next-PC sequencer: commits one PC update per request or runs the exception
// sequence (save EPC, read vector byte, load PC from it).
module pcsrc_ctrl #(
    parameter int         MEM_LAT = 2,
    parameter logic [7:0] VEC_OPC = 8'hFD,
    parameter logic [7:0] VEC_OVF = 8'hFE,
    parameter logic [7:0] VEC_DIV = 8'hFF
) (
    input logic        clk,
    input logic        reset,
    pcsrc_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, COMMIT, EXC_EPC, EXC_MEM, EXC_LOAD, DONE
    } state_t;

    state_t     state, state_d;
    logic [2:0] lat_cnt, lat_cnt_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] vec_q, vec_d;
    logic       pc_write_q, pc_write_d;
    logic       epc_write_q, epc_write_d;
    logic       alu_q, alu_d;
    logic       mem_read_q, mem_read_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       illegal_kind;
    logic       exc_any;
    logic       take;
    logic [2:0] take_sel;

    // Every output flop is loaded with the value belonging to the next state,
    // so outputs appear in the same cycle as the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            lat_cnt     <= 3'd0;
            sel_q       <= 3'b000;
            vec_q       <= 8'h00;
            pc_write_q  <= 1'b0;
            epc_write_q <= 1'b0;
            alu_q       <= 1'b0;
            mem_read_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_d;
            lat_cnt     <= lat_cnt_d;
            sel_q       <= sel_d;
            vec_q       <= vec_d;
            pc_write_q  <= pc_write_d;
            epc_write_q <= epc_write_d;
            alu_q       <= alu_d;
            mem_read_q  <= mem_read_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d      = state;
        lat_cnt_d    = lat_cnt;
        sel_d        = sel_q;
        vec_d        = vec_q;
        pc_write_d   = 1'b0;
        epc_write_d  = 1'b0;
        alu_d        = 1'b0;
        mem_read_d   = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        illegal_kind = bus.req_kind[2] & bus.req_kind[1];
        exc_any      = bus.exc_opcode | bus.exc_overflow | bus.exc_div0 | illegal_kind;
        take         = 1'b0;
        take_sel     = 3'b000;

        case (bus.req_kind)
            3'b000:  begin take = 1'b1;      take_sel = 3'b000; end
            3'b001:  begin take = bus.zero;  take_sel = 3'b010; end
            3'b010:  begin take = ~bus.zero; take_sel = 3'b010; end
            3'b011:  begin take = 1'b1;      take_sel = 3'b001; end
            3'b100:  begin take = 1'b1;      take_sel = 3'b000; end
            3'b101:  begin take = 1'b1;      take_sel = 3'b011; end
            default: begin take = 1'b0;      take_sel = 3'b000; end
        endcase

        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    busy_d = 1'b1;
                    if (exc_any) begin
                        state_d     = EXC_EPC;
                        epc_write_d = 1'b1;
                        alu_d       = 1'b1;
                        sel_d       = 3'b000;
                        if (bus.exc_opcode || illegal_kind)
                            vec_d = VEC_OPC;
                        else if (bus.exc_overflow)
                            vec_d = VEC_OVF;
                        else
                            vec_d = VEC_DIV;
                    end else begin
                        state_d = COMMIT;
                        if (take) begin
                            pc_write_d = 1'b1;
                            sel_d      = take_sel;
                        end
                    end
                end
            end
            COMMIT: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            EXC_EPC: begin
                state_d    = EXC_MEM;
                lat_cnt_d  = 3'd0;
                mem_read_d = 1'b1;
                busy_d     = 1'b1;
                sel_d      = 3'b000;
            end
            // Hold the read strobe until the vector byte has had MEM_LAT cycles.
            EXC_MEM: begin
                busy_d = 1'b1;
                if (lat_cnt == 3'(MEM_LAT - 1)) begin
                    state_d    = EXC_LOAD;
                    sel_d      = 3'b100;
                    pc_write_d = 1'b1;
                end else begin
                    lat_cnt_d  = lat_cnt + 3'd1;
                    mem_read_d = 1'b1;
                end
            end
            EXC_LOAD: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.pcsrc_selector = sel_q;
    assign bus.pc_write       = pc_write_q;
    assign bus.epc_write      = epc_write_q;
    assign bus.alu_pc_minus4  = alu_q;
    assign bus.mem_read       = mem_read_q;
    assign bus.vec_addr       = vec_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;

endmodule
